// File: rtl/player_bullet_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : player_bullet_ctrl
// Description : Player bullet pool for the shooter game. Spawns a bullet at the
//               ship on a fire request, subject to a frame-based cooldown.
//               Moves live bullets upward once per frame and retires them at
//               the top border or on a collision hit. Bullet state is read
//               through an indexed, registered read port.
// Ports       : clk, rst          - clock, async active-high reset
//               i_frame_tick      - one-cycle pulse per video frame
//               i_game_state      - game FSM state (pool active in PLAYING)
//               i_fire            - fire request pulse
//               i_player_x        - ship left-edge x
//               i_hit_valid/idx   - collision hit report (slot index)
//               i_rd_idx          - read-port slot select
//               o_rd_x/y/alive    - selected slot state (1-cycle latency)
//               o_alive_count     - number of live slots (registered)
//               o_fire_ack        - one-cycle pulse when a bullet spawns
// Revision    : 1.0 - initial release
// ============================================================================
module player_bullet_ctrl #(
  parameter int         MAX_PLAYER_BULLET   = 15,
  parameter int         PLAYER_BULLET_SPEED = 4,
  parameter int         MAX_PLAYER_COOLDOWN = 11,
  parameter int         PLAYER_CENTER_Y     = 372,
  parameter int         PLAYER_WIDTH        = 24,
  parameter int         BULLET_WIDTH        = 4,
  parameter int         BULLET_HEIGHT       = 16,
  parameter int         NONE_X              = 720,
  parameter int         NONE_Y              = 500,
  parameter logic [2:0] GAME_PLAYING        = 3'b001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_frame_tick,
  input  logic [2:0] i_game_state,
  input  logic       i_fire,
  input  logic [9:0] i_player_x,
  input  logic       i_hit_valid,
  input  logic [3:0] i_hit_idx,
  input  logic [3:0] i_rd_idx,
  output logic [9:0] o_rd_x,
  output logic [8:0] o_rd_y,
  output logic       o_rd_alive,
  output logic [3:0] o_alive_count,
  output logic       o_fire_ack
);

  // Cooldown counter width; at least one bit even when the cooldown is 0.
  localparam int CD_W = (MAX_PLAYER_COOLDOWN < 2) ? 1 : $clog2(MAX_PLAYER_COOLDOWN + 1);

  localparam logic [9:0]      C_NONE_X    = 10'(NONE_X);
  localparam logic [8:0]      C_NONE_Y    = 9'(NONE_Y);
  localparam logic [8:0]      C_SPEED     = 9'(PLAYER_BULLET_SPEED);
  localparam logic [9:0]      C_SPAWN_DX  = 10'((PLAYER_WIDTH - BULLET_WIDTH) / 2);
  localparam logic [8:0]      C_SPAWN_Y   = 9'(PLAYER_CENTER_Y - BULLET_HEIGHT);
  localparam logic [CD_W-1:0] C_COOLDOWN  = CD_W'(MAX_PLAYER_COOLDOWN);
  localparam logic [3:0]      C_NUM_SLOTS = 4'(MAX_PLAYER_BULLET);

  // Pool state is a pure function of the game state: there is no sequencing,
  // the pool is either held clear or running.
  localparam logic [0:0] ST_IDLE_CLEAR = 1'b0;
  localparam logic [0:0] ST_ACTIVE     = 1'b1;

  logic [9:0]                   r_x [MAX_PLAYER_BULLET];
  logic [8:0]                   r_y [MAX_PLAYER_BULLET];
  logic [MAX_PLAYER_BULLET-1:0] r_alive;
  logic [CD_W-1:0]              r_cooldown;
  logic                         r_fire_pending;

  logic [0:0]                   w_state;
  logic [MAX_PLAYER_BULLET-1:0] w_hit_vec;
  logic [3:0]                   w_free_idx;
  logic                         w_any_free;
  logic                         w_spawn;
  logic [3:0]                   w_pop;
  logic [9:0]                   w_spawn_x;

  assign w_state   = (i_game_state == GAME_PLAYING) ? ST_ACTIVE : ST_IDLE_CLEAR;
  assign w_spawn_x = i_player_x + C_SPAWN_DX;

  // Out-of-range hit indices match no slot and are therefore harmless.
  always_comb begin
    w_hit_vec = '0;
    for (int i = 0; i < MAX_PLAYER_BULLET; i++) begin
      w_hit_vec[i] = i_hit_valid && (i_hit_idx == 4'(i));
    end
  end

  // Lowest-index dead slot, based on pre-edge alive flags so a slot freed by a
  // hit in this same cycle is not eligible.
  always_comb begin
    w_free_idx = '0;
    w_any_free = 1'b0;
    for (int i = MAX_PLAYER_BULLET - 1; i >= 0; i--) begin
      if (!r_alive[i]) begin
        w_free_idx = 4'(i);
        w_any_free = 1'b1;
      end
    end
  end

  assign w_spawn = (w_state == ST_ACTIVE) && i_frame_tick && r_fire_pending &&
                   (r_cooldown == '0) && w_any_free;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < MAX_PLAYER_BULLET; i++) begin
      w_pop = w_pop + 4'(r_alive[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_PLAYER_BULLET; i++) begin
        r_x[i] <= C_NONE_X;
        r_y[i] <= C_NONE_Y;
      end
      r_alive        <= '0;
      r_cooldown     <= '0;
      r_fire_pending <= 1'b0;
      o_rd_x         <= C_NONE_X;
      o_rd_y         <= C_NONE_Y;
      o_rd_alive     <= 1'b0;
      o_alive_count  <= '0;
      o_fire_ack     <= 1'b0;
    end else begin
      // Read port and count sample pre-edge state, giving one cycle of latency.
      if (i_rd_idx < C_NUM_SLOTS) begin
        o_rd_x     <= r_x[i_rd_idx];
        o_rd_y     <= r_y[i_rd_idx];
        o_rd_alive <= r_alive[i_rd_idx];
      end else begin
        o_rd_x     <= C_NONE_X;
        o_rd_y     <= C_NONE_Y;
        o_rd_alive <= 1'b0;
      end
      o_alive_count <= w_pop;

      if (w_state == ST_IDLE_CLEAR) begin
        for (int i = 0; i < MAX_PLAYER_BULLET; i++) begin
          r_x[i] <= C_NONE_X;
          r_y[i] <= C_NONE_Y;
        end
        r_alive        <= '0;
        r_cooldown     <= '0;
        r_fire_pending <= 1'b0;
        o_fire_ack     <= 1'b0;
      end else begin
        o_fire_ack <= w_spawn;

        // A fire coinciding with a tick survives that tick's consumption.
        if (i_fire) begin
          r_fire_pending <= 1'b1;
        end else if (i_frame_tick) begin
          r_fire_pending <= 1'b0;
        end

        if (w_spawn) begin
          r_cooldown <= C_COOLDOWN;
        end else if (i_frame_tick && (r_cooldown != '0)) begin
          r_cooldown <= r_cooldown - 1'b1;
        end

        // Per-slot priority: spawn (into a dead slot), then hit, then move.
        for (int i = 0; i < MAX_PLAYER_BULLET; i++) begin
          if (w_spawn && (w_free_idx == 4'(i))) begin
            r_x[i]     <= w_spawn_x;
            r_y[i]     <= C_SPAWN_Y;
            r_alive[i] <= 1'b1;
          end else if (r_alive[i] && w_hit_vec[i]) begin
            r_x[i]     <= C_NONE_X;
            r_y[i]     <= C_NONE_Y;
            r_alive[i] <= 1'b0;
          end else if (r_alive[i] && i_frame_tick) begin
            if (r_y[i] < C_SPEED) begin
              r_x[i]     <= C_NONE_X;
              r_y[i]     <= C_NONE_Y;
              r_alive[i] <= 1'b0;
            end else begin
              r_y[i] <= r_y[i] - C_SPEED;
            end
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_player_bullet_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_player_bullet_ctrl
// Description : Directed self-checking bench for player_bullet_ctrl. Instance
//               A uses default parameters; instance B uses speed 1 and zero
//               cooldown to fill the whole pool quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_player_bullet_ctrl;

  logic clk;
  logic rst;

  logic       a_tick, a_fire, a_hv;
  logic [2:0] a_gs;
  logic [9:0] a_px;
  logic [3:0] a_hi, a_ri;
  logic [9:0] a_rx;
  logic [8:0] a_ry;
  logic       a_ra, a_ack;
  logic [3:0] a_cnt;

  logic       b_tick, b_fire, b_hv;
  logic [2:0] b_gs;
  logic [9:0] b_px;
  logic [3:0] b_hi, b_ri;
  logic [9:0] b_rx;
  logic [8:0] b_ry;
  logic       b_ra, b_ack;
  logic [3:0] b_cnt;

  int checks;
  int failures;

  player_bullet_ctrl u_dut_a (
    .clk(clk), .rst(rst), .i_frame_tick(a_tick), .i_game_state(a_gs),
    .i_fire(a_fire), .i_player_x(a_px), .i_hit_valid(a_hv), .i_hit_idx(a_hi),
    .i_rd_idx(a_ri), .o_rd_x(a_rx), .o_rd_y(a_ry), .o_rd_alive(a_ra),
    .o_alive_count(a_cnt), .o_fire_ack(a_ack)
  );

  player_bullet_ctrl #(.PLAYER_BULLET_SPEED(1), .MAX_PLAYER_COOLDOWN(0)) u_dut_b (
    .clk(clk), .rst(rst), .i_frame_tick(b_tick), .i_game_state(b_gs),
    .i_fire(b_fire), .i_player_x(b_px), .i_hit_valid(b_hv), .i_hit_idx(b_hi),
    .i_rd_idx(b_ri), .o_rd_x(b_rx), .o_rd_y(b_ry), .o_rd_alive(b_ra),
    .o_alive_count(b_cnt), .o_fire_ack(b_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step_a(input logic f, input logic t, input logic hv, input logic [3:0] hi);
    a_fire = f; a_tick = t; a_hv = hv; a_hi = hi;
    @(posedge clk); #1;
    a_fire = 1'b0; a_tick = 1'b0; a_hv = 1'b0; a_hi = 4'd0;
  endtask

  task automatic step_b(input logic f, input logic t, input logic hv, input logic [3:0] hi);
    b_fire = f; b_tick = t; b_hv = hv; b_hi = hi;
    @(posedge clk); #1;
    b_fire = 1'b0; b_tick = 1'b0; b_hv = 1'b0; b_hi = 4'd0;
  endtask

  task automatic read_a(input logic [3:0] idx);
    a_ri = idx;
    @(posedge clk); #1;
  endtask

  task automatic read_b(input logic [3:0] idx);
    b_ri = idx;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
  endtask

  initial begin
    int spawns;
    int budget;
    checks = 0; failures = 0;
    rst = 1'b1;
    a_tick = 0; a_fire = 0; a_hv = 0; a_hi = 0; a_ri = 0; a_gs = 3'b000; a_px = 10'd302;
    b_tick = 0; b_fire = 0; b_hv = 0; b_hi = 0; b_ri = 0; b_gs = 3'b000; b_px = 10'd100;
    #12;
    chk("reset_rd_x", a_rx, 720);
    chk("reset_rd_y", a_ry, 500);
    chk("reset_rd_alive", a_ra, 0);
    chk("reset_count", a_cnt, 0);
    chk("reset_ack", a_ack, 0);
    @(negedge clk); rst = 1'b0; #1;
    a_gs = 3'b001; b_gs = 3'b001;

    // First spawn; a fire coinciding with a tick is held for the next tick.
    step_a(1, 1, 0, 0);
    chk("same_cycle_fire_no_ack", a_ack, 0);
    step_a(0, 1, 0, 0);
    chk("first_spawn_ack", a_ack, 1);
    read_a(0);
    chk("slot0_x", a_rx, 312);
    chk("slot0_y", a_ry, 356);
    chk("slot0_alive", a_ra, 1);
    chk("count_one", a_cnt, 1);
    step_a(0, 1, 0, 0);
    chk("cooldown_no_ack", a_ack, 0);
    read_a(0);
    chk("slot0_y_moved", a_ry, 352);

    // Lifetime: y reaches 0 after 89 ticks, tick 90 retires it.
    for (int i = 0; i < 88; i++) step_a(0, 1, 0, 0);
    read_a(0);
    chk("slot0_y_zero", a_ry, 0);
    chk("slot0_alive_at_zero", a_ra, 1);
    step_a(0, 1, 0, 0);
    read_a(0);
    chk("retired_x", a_rx, 720);
    chk("retired_y", a_ry, 500);
    chk("retired_alive", a_ra, 0);
    chk("retired_count", a_cnt, 0);

    // Fire every frame: spawns on ticks 0, 12, 24.
    pulse_reset();
    for (int t = 0; t <= 24; t++) begin
      step_a(1, 0, 0, 0);
      step_a(0, 1, 0, 0);
      chk($sformatf("held_fire_ack_t%0d", t), a_ack, (t % 12 == 0) ? 1 : 0);
    end
    read_a(0);
    chk("held_slot0_y", a_ry, 260);
    read_a(1);
    chk("held_slot1_y", a_ry, 308);
    chk("held_slot1_alive", a_ra, 1);
    read_a(2);
    chk("held_slot2_y", a_ry, 356);
    chk("held_slot2_x", a_rx, 312);
    read_a(3);
    chk("held_slot3_dead", a_ra, 0);
    chk("held_count", a_cnt, 3);

    // Hits on an out-of-range index or a dead slot change nothing.
    step_a(0, 0, 1, 4'd15);
    step_a(0, 0, 1, 4'd5);
    read_a(0);
    chk("nohit_slot0_y", a_ry, 260);
    chk("nohit_count", a_cnt, 3);
    read_a(15);
    chk("rd15_x", a_rx, 720);
    chk("rd15_y", a_ry, 500);
    chk("rd15_alive", a_ra, 0);
    step_a(0, 0, 1, 4'd1);
    read_a(1);
    chk("hit_slot1_dead", a_ra, 0);
    chk("hit_slot1_x", a_rx, 720);
    chk("hit_count", a_cnt, 2);

    // Pool full with speed 1 and no cooldown.
    for (int t = 0; t < 15; t++) begin
      step_b(1, 0, 0, 0);
      step_b(0, 1, 0, 0);
      chk($sformatf("fill_ack_t%0d", t), b_ack, 1);
    end
    read_b(0);
    chk("full_count", b_cnt, 15);
    chk("full_slot0_y", b_ry, 342);
    chk("full_slot0_x", b_rx, 110);
    step_b(1, 0, 0, 0);
    step_b(0, 1, 0, 0);
    chk("full_no_ack", b_ack, 0);
    step_b(1, 0, 0, 0);
    step_b(0, 1, 1, 4'd3);
    chk("hit_tick_no_ack", b_ack, 0);
    read_b(3);
    chk("hit_slot3_dead", b_ra, 0);
    chk("hit_slot3_count", b_cnt, 14);
    step_b(1, 0, 0, 0);
    step_b(0, 1, 0, 0);
    chk("respawn_ack", b_ack, 1);
    read_b(3);
    chk("respawn_slot3_alive", b_ra, 1);
    chk("respawn_slot3_y", b_ry, 356);
    chk("respawn_count", b_cnt, 15);

    // Seven live bullets, then leave PLAYING.
    pulse_reset();
    spawns = 0;
    budget = 200;
    while (spawns < 7 && budget > 0) begin
      step_a(1, 0, 0, 0);
      step_a(0, 1, 0, 0);
      if (a_ack) spawns++;
      budget--;
    end
    chk("seven_spawn_budget", spawns, 7);
    read_a(0);
    chk("seven_count", a_cnt, 7);
    a_gs = 3'b100;
    step_a(1, 0, 0, 0);
    step_a(0, 0, 0, 0);
    chk("defeat_count", a_cnt, 0);
    step_a(1, 1, 0, 0);
    chk("defeat_fire_ignored", a_ack, 0);
    read_a(0);
    chk("defeat_slot0_dead", a_ra, 0);
    a_gs = 3'b001;
    step_a(1, 0, 0, 0);
    step_a(0, 1, 0, 0);
    chk("replay_spawn_ack", a_ack, 1);
    read_a(0);
    chk("replay_slot0_alive", a_ra, 1);
    chk("replay_slot0_y", a_ry, 356);

    // Asynchronous reset mid-operation.
    #3 rst = 1'b1;
    #1;
    chk("async_rst_alive", a_ra, 0);
    chk("async_rst_count", a_cnt, 0);
    chk("async_rst_y", a_ry, 500);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
